// File: rtl/axi_burst_scheduler_if.sv
// Requester and burst-master user-port bundle for axi_burst_scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic's view.
interface axi_burst_scheduler_if #(
  parameter int ADDR_W  = 32,
  parameter int BEATS_W = 16
);
  logic               req0_valid;
  logic               req0_w_r;
  logic [ADDR_W-1:0]  req0_addr;
  logic [BEATS_W-1:0] req0_beats;
  logic               req0_ready;
  logic               req0_done;
  logic               req0_err;

  logic               req1_valid;
  logic               req1_w_r;
  logic [ADDR_W-1:0]  req1_addr;
  logic [BEATS_W-1:0] req1_beats;
  logic               req1_ready;
  logic               req1_done;
  logic               req1_err;

  logic [1:0]         grant;
  logic               m_start;
  logic               m_w_r;
  logic [7:0]         m_burst_len;
  logic [ADDR_W-1:0]  m_addr;
  logic               m_free;
  logic [1:0]         m_status;

  modport master (
    input  req0_valid, req0_w_r, req0_addr, req0_beats,
    output req0_ready, req0_done, req0_err,
    input  req1_valid, req1_w_r, req1_addr, req1_beats,
    output req1_ready, req1_done, req1_err,
    output grant, m_start, m_w_r, m_burst_len, m_addr,
    input  m_free, m_status
  );

  modport slave (
    output req0_valid, req0_w_r, req0_addr, req0_beats,
    input  req0_ready, req0_done, req0_err,
    output req1_valid, req1_w_r, req1_addr, req1_beats,
    input  req1_ready, req1_done, req1_err,
    input  grant, m_start, m_w_r, m_burst_len, m_addr,
    output m_free, m_status
  );
endinterface

// File: rtl/axi_burst_scheduler.sv
// Two-requester arbiter that splits transfers into 4 KB-safe INCR bursts for one burst master.
// Define AXI_SCHED_FIXED_PRIO_EN to make requester 0 always win instead of round-robin.
module axi_burst_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 256,
  parameter int BEATS_W   = 16
) (
  input logic                   aclk,
  input logic                   areset,
  axi_burst_scheduler_if.master bus
);

  localparam int LOG2_BYTES = $clog2(DATA_W / 8);
  localparam int CW         = ((BEATS_W > 13) ? BEATS_W : 13) + 1;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [BEATS_W-1:0] r_remaining;
  logic [8:0]         r_nb;
  logic [7:0]         r_mLen;
  logic [1:0]         r_grant;
  logic               r_err;

  logic               w_anyValid;
  logic               w_winner;
  logic               w_winWr;
  logic [ADDR_W-1:0]  w_winAddr;
  logic [BEATS_W-1:0] w_winBeats;
  logic [12:0]        w_bndBytes;
  logic [CW-1:0]      w_bnd;
  logic [CW-1:0]      w_remW;
  logic [CW-1:0]      w_maxW;
  logic [CW-1:0]      w_nbW;
  logic [8:0]         w_nb;
  logic [8:0]         w_lenW;
  logic [ADDR_W-1:0]  w_addrStep;
  logic [BEATS_W-1:0] w_remAfter;
  logic               w_ready0;
  logic               w_ready1;
  logic               w_done0;
  logic               w_done1;
  logic               w_err0;
  logic               w_err1;
  logic               w_start;
  logic               w_unusedStatus;

  assign w_anyValid     = bus.req0_valid | bus.req1_valid;
  assign w_unusedStatus = bus.m_status[0];

`ifdef AXI_SCHED_FIXED_PRIO_EN
  assign w_winner = ~bus.req0_valid;
`else
  logic r_rrPtr;

  // The pointer names the preferred requester when both ask in the same cycle.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) w_winner = r_rrPtr;
    else                                  w_winner = bus.req1_valid;
  end

  always_ff @(posedge aclk) begin
    if (areset)                             r_rrPtr <= 1'b0;
    else if (r_state == IDLE && w_anyValid) r_rrPtr <= ~w_winner;
  end
`endif

  assign w_winWr    = w_winner ? bus.req1_w_r   : bus.req0_w_r;
  assign w_winAddr  = w_winner ? bus.req1_addr  : bus.req0_addr;
  assign w_winBeats = w_winner ? bus.req1_beats : bus.req0_beats;

  // Beats left before the next 4 KB page; 13 bits so a page-aligned address yields the full page.
  assign w_bndBytes = 13'h1000 - {1'b0, r_addr[11:0]};
  assign w_bnd      = CW'(w_bndBytes >> LOG2_BYTES);
  assign w_remW     = CW'(r_remaining);
  assign w_maxW     = CW'(MAX_BURST);

  always_comb begin
    w_nbW = w_remW;
    if (w_maxW < w_nbW) w_nbW = w_maxW;
    if (w_bnd < w_nbW)  w_nbW = w_bnd;
  end

  assign w_nb       = w_nbW[8:0];
  assign w_lenW     = w_nb - 9'd1;
  assign w_addrStep = ADDR_W'(r_nb) << LOG2_BYTES;
  assign w_remAfter = r_remaining - BEATS_W'(r_nb);

  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_ready0    = 1'b0;
    w_ready1    = 1'b0;
    w_done0     = 1'b0;
    w_done1     = 1'b0;
    w_err0      = 1'b0;
    w_err1      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyValid && !areset) begin
          w_ready0    = ~w_winner;
          w_ready1    = w_winner;
          w_nextState = (w_winBeats == '0) ? DONE : CALC;
        end
      end
      CALC:  w_nextState = ISSUE;
      ISSUE: begin
        w_start = 1'b1;
        if (!bus.m_free) w_nextState = RUN;
      end
      RUN: begin
        if (bus.m_free) w_nextState = (w_remAfter == '0) ? DONE : CALC;
      end
      DONE: begin
        w_done0     = r_grant[0];
        w_done1     = r_grant[1];
        w_err0      = r_grant[0] & r_err;
        w_err1      = r_grant[1] & r_err;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Transfer context: latched on accept, advanced one burst at a time as the master frees up.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_nb        <= '0;
      r_mLen      <= '0;
      r_grant     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyValid) begin
            r_wr        <= w_winWr;
            r_addr      <= w_winAddr;
            r_remaining <= w_winBeats;
            r_grant     <= w_winner ? 2'b10 : 2'b01;
            r_err       <= 1'b0;
          end
        end
        CALC: begin
          r_nb   <= w_nb;
          r_mLen <= w_lenW[7:0];
        end
        RUN: begin
          if (bus.m_status[1]) r_err <= 1'b1;
          if (bus.m_free) begin
            r_addr      <= r_addr + w_addrStep;
            r_remaining <= w_remAfter;
          end
        end
        DONE: begin
          r_grant <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready  = w_ready0;
  assign bus.req1_ready  = w_ready1;
  assign bus.req0_done   = w_done0;
  assign bus.req1_done   = w_done1;
  assign bus.req0_err    = w_err0;
  assign bus.req1_err    = w_err1;
  assign bus.grant       = r_grant;
  assign bus.m_start     = w_start;
  assign bus.m_w_r       = r_wr;
  assign bus.m_burst_len = r_mLen;
  assign bus.m_addr      = r_addr;

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Directed bench for axi_burst_scheduler: vector table of transfers plus hand-written
// arbitration, zero-length and mid-transfer reset sequences against a simple master model.
module tb_axi_burst_scheduler;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int MAX_BURST = 256;
   localparam int BEATS_W   = 16;

   logic aclk = 1'b0;
   logic areset;

   always #5 aclk = ~aclk;

   axi_burst_scheduler_if #(.ADDR_W(ADDR_W), .BEATS_W(BEATS_W)) bus ();

   axi_burst_scheduler #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .BEATS_W(BEATS_W)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cycle = 0;

   always @(posedge aclk) cycle++;

   // Burst master model: takes a burst when free, stays busy a few cycles, reports status.
   int busyCnt = 0;
   int burstNum = 0;
   int errBurst = -1;
   int freeRiseCycle[$];

   always @(negedge aclk) begin
      if (areset) begin
         bus.m_free = 1'b1;
         bus.m_status = 2'b00;
         busyCnt = 0;
      end else if (bus.m_free && bus.m_start) begin
         bus.m_free = 1'b0;
         busyCnt = 3;
         bus.m_status = (burstNum == errBurst) ? 2'b10 : 2'b00;
         burstNum++;
      end else if (!bus.m_free) begin
         if (busyCnt == 0) begin
            bus.m_free = 1'b1;
            bus.m_status = 2'b00;
            freeRiseCycle.push_back(cycle);
         end else begin
            busyCnt--;
         end
      end
   end

   // Monitor: logs every burst start, accept and completion seen mid-cycle.
   logic [7:0]  logLen[$];
   logic [31:0] logAddr[$];
   logic        logWr[$];
   logic [1:0]  logGrant[$];
   int          startCycle[$];
   int          startRise = 0;
   logic        prevStart = 1'b0;
   int          readyCycle = 0;
   int          doneCycle = 0;
   int          done0Cnt = 0;
   int          done1Cnt = 0;
   logic        lastErr0 = 1'b0;
   logic        lastErr1 = 1'b0;

   always @(negedge aclk) begin
      if (bus.m_start && !prevStart) begin
         startRise++;
         logLen.push_back(bus.m_burst_len);
         logAddr.push_back(bus.m_addr);
         logWr.push_back(bus.m_w_r);
         logGrant.push_back(bus.grant);
         startCycle.push_back(cycle);
      end
      prevStart = bus.m_start;
      if (bus.req0_ready || bus.req1_ready) readyCycle = cycle;
      if (bus.req0_done) begin
         done0Cnt++;
         lastErr0 = bus.req0_err;
         doneCycle = cycle;
      end
      if (bus.req1_done) begin
         done1Cnt++;
         lastErr1 = bus.req1_err;
         doneCycle = cycle;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic setReq(input int idx, input logic valid, input logic wr,
                         input logic [31:0] addr, input logic [15:0] beats);
      if (idx == 0) begin
         bus.req0_valid = valid; bus.req0_w_r = wr; bus.req0_addr = addr; bus.req0_beats = beats;
      end else begin
         bus.req1_valid = valid; bus.req1_w_r = wr; bus.req1_addr = addr; bus.req1_beats = beats;
      end
   endtask

   // Raises one request, holds it until ready is seen, then withdraws it after the accept edge.
   task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr, input logic [15:0] beats);
      logic gotReady;
      int n;
      @(posedge aclk); #1;
      setReq(idx, 1'b1, wr, addr, beats);
      gotReady = 1'b0;
      n = 0;
      while (!gotReady && n < 200) begin
         @(negedge aclk);
         n++;
         gotReady = (idx == 0) ? bus.req0_ready : bus.req1_ready;
      end
      checkOutput($sformatf("req%0d ready seen", idx), {63'd0, gotReady}, 64'd1);
      @(posedge aclk); #1;
      setReq(idx, 1'b0, 1'b0, 32'd0, 16'd0);
   endtask

   task automatic waitDone(input int idx, input int base);
      logic seen;
      int n;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 4000) begin
         @(negedge aclk); #1;
         n++;
         seen = ((idx == 0) ? done0Cnt : done1Cnt) > base;
      end
      checkOutput($sformatf("req%0d done seen", idx), {63'd0, seen}, 64'd1);
   endtask

   typedef struct {
      int              req;
      logic            wr;
      logic [31:0]     addr;
      logic [15:0]     beats;
      int              errIdx;
      int              nBursts;
      logic [2:0][7:0]  len;
      logic [2:0][31:0] bAddr;
      logic            err;
   } vec_t;

   vec_t vecs[6];

   task automatic runVector(input int v);
      int lb, fb, sb, d0, d1, myBase, otherBase, otherNow;
      logic myErr;
      lb = logLen.size();
      fb = freeRiseCycle.size();
      sb = startRise;
      d0 = done0Cnt;
      d1 = done1Cnt;
      errBurst = (vecs[v].errIdx < 0) ? -1 : burstNum + vecs[v].errIdx;
      applyStimulus(vecs[v].req, vecs[v].wr, vecs[v].addr, vecs[v].beats);
      myBase = (vecs[v].req == 0) ? d0 : d1;
      waitDone(vecs[v].req, myBase);
      checkOutput($sformatf("v%0d start count", v), 64'(startRise - sb), 64'(vecs[v].nBursts));
      for (int i = 0; i < vecs[v].nBursts; i++) begin
         checkOutput($sformatf("v%0d burst%0d len", v, i), 64'(logLen[lb+i]), 64'(vecs[v].len[i]));
         checkOutput($sformatf("v%0d burst%0d addr", v, i), 64'(logAddr[lb+i]), 64'(vecs[v].bAddr[i]));
         checkOutput($sformatf("v%0d burst%0d w_r", v, i), 64'(logWr[lb+i]), 64'(vecs[v].wr));
         checkOutput($sformatf("v%0d burst%0d grant", v, i), 64'(logGrant[lb+i]),
                     (vecs[v].req == 0) ? 64'd1 : 64'd2);
      end
      checkOutput($sformatf("v%0d accept-to-start", v), 64'(startCycle[lb] - readyCycle), 64'd2);
      if (vecs[v].nBursts > 1)
         checkOutput($sformatf("v%0d free-to-restart>=2", v),
                     {63'd0, (startCycle[lb+1] - freeRiseCycle[fb]) >= 2}, 64'd1);
      myErr = (vecs[v].req == 0) ? lastErr0 : lastErr1;
      checkOutput($sformatf("v%0d done err", v), {63'd0, myErr}, {63'd0, vecs[v].err});
      otherBase = (vecs[v].req == 0) ? d1 : d0;
      otherNow  = (vecs[v].req == 0) ? done1Cnt : done0Cnt;
      checkOutput($sformatf("v%0d other done", v), 64'(otherNow - otherBase), 64'd0);
      errBurst = -1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " grant"}, 64'(bus.grant), 64'd0);
      checkOutput({tag, " m_start"}, 64'(bus.m_start), 64'd0);
      checkOutput({tag, " m_addr"}, 64'(bus.m_addr), 64'd0);
      checkOutput({tag, " m_burst_len/w_r"}, 64'({bus.m_burst_len, bus.m_w_r}), 64'd0);
      checkOutput({tag, " req flags"}, 64'({bus.req0_ready, bus.req0_done, bus.req0_err,
                                            bus.req1_ready, bus.req1_done, bus.req1_err}), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int expWin[4];
      int quota[2];
      int win, n, sb, d0, d1;
      logic seen;

      vecs[0] = '{req:0, wr:1'b0, addr:32'h0000_0F00, beats:16'd40,  errIdx:-1, nBursts:2,
                  len:{8'd0, 8'd7, 8'd31}, bAddr:{32'h0, 32'h1000, 32'h0F00}, err:1'b0};
      vecs[1] = '{req:1, wr:1'b1, addr:32'h0000_0000, beats:16'd600, errIdx:-1, nBursts:3,
                  len:{8'd87, 8'd255, 8'd255}, bAddr:{32'h1000, 32'h800, 32'h0}, err:1'b0};
      vecs[2] = '{req:0, wr:1'b1, addr:32'h0000_0000, beats:16'd600, errIdx:1, nBursts:3,
                  len:{8'd87, 8'd255, 8'd255}, bAddr:{32'h1000, 32'h800, 32'h0}, err:1'b1};
      vecs[3] = '{req:1, wr:1'b0, addr:32'hFFFF_FFF8, beats:16'd3,   errIdx:-1, nBursts:2,
                  len:{8'd0, 8'd1, 8'd0}, bAddr:{32'h0, 32'h0, 32'hFFFF_FFF8}, err:1'b0};
      vecs[4] = '{req:0, wr:1'b0, addr:32'h0000_3000, beats:16'd256, errIdx:-1, nBursts:1,
                  len:{8'd0, 8'd0, 8'd255}, bAddr:{32'h0, 32'h0, 32'h3000}, err:1'b0};
      vecs[5] = '{req:1, wr:1'b1, addr:32'h0000_1FF8, beats:16'd1,   errIdx:-1, nBursts:1,
                  len:{8'd0, 8'd0, 8'd0}, bAddr:{32'h0, 32'h0, 32'h1FF8}, err:1'b0};

      areset = 1'b1;
      setReq(0, 1'b0, 1'b0, 32'd0, 16'd0);
      setReq(1, 1'b0, 1'b0, 32'd0, 16'd0);
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(negedge aclk);
      checkAllZero("reset");

      for (int v = 0; v < 6; v++) runVector(v);

      // Both requesters held valid for two transfers each.
`ifdef AXI_SCHED_FIXED_PRIO_EN
      expWin = '{0, 0, 1, 1};
`else
      expWin = '{0, 1, 0, 1};
`endif
      quota = '{2, 2};
      @(posedge aclk); #1;
      setReq(0, 1'b1, 1'b0, 32'h100, 16'd1);
      setReq(1, 1'b1, 1'b1, 32'h200, 16'd1);
      for (int k = 0; k < 4; k++) begin
         win = -1;
         n = 0;
         while (win < 0 && n < 200) begin
            @(negedge aclk);
            n++;
            if (bus.req0_ready) win = 0;
            else if (bus.req1_ready) win = 1;
         end
         checkOutput($sformatf("arb grant %0d", k), 64'(win), 64'(expWin[k]));
         @(posedge aclk); #1;
         if (win >= 0) begin
            quota[win]--;
            if (quota[win] == 0) setReq(win, 1'b0, 1'b0, 32'd0, 16'd0);
         end
      end
      setReq(0, 1'b0, 1'b0, 32'd0, 16'd0);
      setReq(1, 1'b0, 1'b0, 32'd0, 16'd0);
      repeat (30) @(posedge aclk);

      // Zero-length transfer: done the cycle after ready, no burst issued.
      sb = startRise;
      d0 = done0Cnt;
      applyStimulus(0, 1'b0, 32'h40, 16'd0);
      waitDone(0, d0);
      checkOutput("zero-len ready-to-done", 64'(doneCycle - readyCycle), 64'd1);
      checkOutput("zero-len no start", 64'(startRise - sb), 64'd0);
      checkOutput("zero-len err", {63'd0, lastErr0}, 64'd0);

      // Reset while the master is running a burst abandons the transfer.
      d1 = done1Cnt;
      applyStimulus(1, 1'b1, 32'h0, 16'd600);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 200) begin
         @(negedge aclk); #1;
         n++;
         seen = !bus.m_free && !bus.m_start;
      end
      checkOutput("reached RUN", {63'd0, seen}, 64'd1);
      @(posedge aclk); #1 areset = 1'b1;
      @(posedge aclk); #1 areset = 1'b0;
      @(negedge aclk);
      checkAllZero("mid-run reset");
      repeat (20) @(posedge aclk);
      checkOutput("no done after reset", 64'(done1Cnt - d1), 64'd0);

      runVector(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_burst_scheduler.md
Name: axi_burst_scheduler

Overview:
- Sits between two transfer requesters and the single AXI burst master.
- Arbitrates between the two requesters, accepts a transfer of arbitrary length, and splits it into legal INCR bursts (≤ MAX_BURST beats, never crossing a 4 KB boundary).
- Sequences each burst through the master's user start/free handshake, then reports completion and sticky error per requester.
- Exports the current grant so top-level data muxing can follow it.

Parameters:
- ADDR_W, 32, address width; matches the burst master.
- DATA_W, 64, data width; beat size is DATA_W/8 bytes (power of two, 8..128 bytes).
- MAX_BURST, 256, maximum beats per burst (1..256).
- BEATS_W, 16, width of the requested total beat count.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 transfer request; held until req0_ready
- req0_w_r  in  1  0 = write, 1 = read
- req0_addr  in  ADDR_W  start byte address, beat-aligned
- req0_beats  in  BEATS_W  total beats; 0 allowed
- req0_ready  out  1  one-cycle accept pulse
- req0_done  out  1  one-cycle completion pulse
- req0_err  out  1  error flag, valid with req0_done
- req1_valid, req1_w_r, req1_addr, req1_beats, req1_ready, req1_done, req1_err  same as requester 0
- grant  out  2  one-hot active requester; 0 when idle
- m_start  out  1  to master user_start (level)
- m_w_r  out  1  to master user_w_r
- m_burst_len  out  8  to master user_burst_len_in (beats-1)
- m_addr  out  ADDR_W  to master user_addr_in
- m_free  in  1  from master user_free
- m_status  in  2  from master user_status

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE and the round-robin pointer is set to requester 0. Reset mid-transfer abandons the transfer: no done pulse, m_start drops the next cycle.
- FSM states: IDLE, CALC, ISSUE, RUN, DONE.
- IDLE:
  - If any valid, pick a winner. Round-robin: the pointer names the preferred requester; on a win the pointer moves to the other requester.
  - Latch w_r, addr and beats; pulse the winner's ready; set grant.
  - Beats == 0 → DONE. Otherwise → CALC.
- CALC:
  - bnd = (4096 - addr[11:0]) >> log2(DATA_W/8).
  - nb = min(remaining, MAX_BURST, bnd), registered. Arithmetic is wide enough that bnd = 4096/beat size does not truncate.
  - m_burst_len = nb-1; m_addr = current addr; → ISSUE.
- ISSUE:
  - m_start = 1, with m_w_r, m_addr and m_burst_len stable.
  - When m_free == 0 is sampled, the master has accepted → RUN.
- RUN:
  - m_start = 0, address and length held.
  - Every cycle, if m_status[1] == 1, set the sticky err.
  - When m_free == 1 is sampled: addr += nb·(DATA_W/8) and remaining -= nb.
  - remaining == 0 → DONE; otherwise → CALC.
  - A new burst's m_start therefore never asserts earlier than 2 cycles after m_free rises.
- DONE:
  - One-cycle req*_done pulse on the granted requester, with req*_err = sticky err.
  - Clear grant and sticky err; → IDLE.
- Boundary conditions:
  - Both valid in the same cycle → the pointer decides.
  - A requester that withdraws valid before ready is simply not served.
  - Address wraps modulo 2^ADDR_W.
  - req*_ready is never asserted while the FSM is outside IDLE.
- Latency: IDLE accept → first m_start = 2 cycles (accept, CALC).

Optional Feature:
- Macro: AXI_SCHED_FIXED_PRIO_EN.
- Defined: requester 0 always wins over requester 1; the pointer is unused.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then req0 write addr 0x0000_0F00, beats 40, DATA_W 64 → two bursts: len 31 @0x0F00, then len 7 @0x1000; one req0_done, req0_err = 0.
- req1 read addr 0x0, beats 600 → bursts len 255 @0x0, len 255 @0x800, len 87 @0x1000; exactly three m_start assertions, then req1_done.
- req0 and req1 valid in the same cycle, back-to-back, 1 beat each, four transfers → grants 0, 1, 0, 1. With AXI_SCHED_FIXED_PRIO_EN and both held valid → 0, 0, 0…
- Master model returns m_status = 2'b10 during the second of three bursts → all bursts still issued; done with err = 1. The following transfer reports err = 0.
- req0 beats = 0 → ready, then done 1 cycle later; m_start never asserted.
- areset asserted while in RUN → next cycle all outputs 0 and grant 0, no done pulse; a subsequent request is served normally.
